// File: rtl/systolic_row_collector.sv
// systolic_row_collector
// Re-aligns skewed per-lane {enable, data} streams from the systolic array edge
// into whole rows, buffers up to BUF_DEPTH rows, and hands them to writeback
// over a valid/ready handshake. A sticky flag records any dropped lane element.
// Optional build macro ROW_COLLECTOR_CNT_EN adds row_count_out (popped-row
// counter) and lane_skew_max_out (largest per-lane occupancy).
module systolic_row_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_LANES-1:0]            lane_en_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_in,
    output logic                            row_valid_out,
    input  logic                            row_ready_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] row_data_out,
    output logic                            overflow_err,
`ifdef ROW_COLLECTOR_CNT_EN
    output logic [15:0]                     row_count_out,
    output logic [$clog2(BUF_DEPTH):0]      lane_skew_max_out,
`endif
    input  logic                            err_clear_in
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Row storage and per-element fill flags
    logic [DATA_WIDTH-1:0] row_buf_q [BUF_DEPTH][NUM_LANES];
    logic [NUM_LANES-1:0]  filled_q  [BUF_DEPTH];
    logic [NUM_LANES-1:0]  filled_d  [BUF_DEPTH];

    // Independent write pointer per lane, one shared read pointer
    ptr_t wptr_q [NUM_LANES];
    ptr_t wptr_d [NUM_LANES];
    ptr_t rptr_q;
    ptr_t rptr_d;

    logic [NUM_LANES-1:0] lane_we;
    logic [NUM_LANES-1:0] lane_drop;
    logic                 pop;
    logic                 overflow_q;
    logic                 overflow_d;

    // Row presentation is driven from registered state only
    assign row_valid_out = &filled_q[rptr_q];
    assign pop           = row_valid_out && row_ready_in;
    assign overflow_err  = overflow_q;

    // Unpack the entry under the read pointer onto the output bus
    always_comb begin
        row_data_out = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            row_data_out[k*DATA_WIDTH +: DATA_WIDTH] = row_buf_q[rptr_q][k];
        end
    end

    // Next-state for fill flags and pointers: pop clears first, then lane writes
    // may claim the just-freed entry in the same cycle
    always_comb begin
        filled_d  = filled_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        lane_we   = '0;
        lane_drop = '0;
        if (pop) begin
            filled_d[rptr_q] = '0;
            rptr_d           = rptr_q + ptr_t'(1);
        end
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (lane_en_in[k]) begin
                if (!filled_q[wptr_q[k]][k] || (pop && (wptr_q[k] == rptr_q))) begin
                    lane_we[k]               = 1'b1;
                    filled_d[wptr_q[k]][k]   = 1'b1;
                    wptr_d[k]                = wptr_q[k] + ptr_t'(1);
                end else begin
                    lane_drop[k] = 1'b1;
                end
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_comb begin
        overflow_d = overflow_q;
        if (err_clear_in) begin
            overflow_d = 1'b0;
        end
        if (|lane_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                filled_q[e] <= '0;
            end
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                wptr_q[k] <= '0;
            end
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            filled_q   <= filled_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Element storage: each accepted lane element lands at its own lane's write pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    row_buf_q[e][k] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                if (lane_we[k]) begin
                    row_buf_q[wptr_q[k]][k] <= lane_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef ROW_COLLECTOR_CNT_EN
    logic [15:0]      row_count_q;
    logic [OCC_W-1:0] skew_d;
    logic [OCC_W-1:0] skew_q;

    assign row_count_out     = row_count_q;
    assign lane_skew_max_out = skew_q;

    // Elements written minus rows popped equals the lane's filled-flag count
    always_comb begin
        logic [OCC_W-1:0] occ;
        skew_d = '0;
        occ    = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            occ = '0;
            for (int unsigned e = 0; e < BUF_DEPTH; e++) begin
                occ = occ + OCC_W'(filled_d[e][k]);
            end
            if (occ > skew_d) begin
                skew_d = occ;
            end
        end
    end

    // Popped-row counter (wraps naturally) and registered skew maximum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_count_q <= '0;
            skew_q      <= '0;
        end else begin
            if (pop) begin
                row_count_q <= row_count_q + 16'd1;
            end
            skew_q <= skew_d;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_row_collector.sv
// Directed self-checking bench for systolic_row_collector (4 lanes x 32 bits, depth 4).
module tb_systolic_row_collector;

    logic         clk;
    logic         rstn;
    logic [3:0]   lane_en_in;
    logic [127:0] lane_data_in;
    logic         row_valid_out;
    logic         row_ready_in;
    logic [127:0] row_data_out;
    logic         overflow_err;
    logic         err_clear_in;
`ifdef ROW_COLLECTOR_CNT_EN
    logic [15:0]  row_count_out;
    logic [2:0]   lane_skew_max_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    systolic_row_collector #(
        .DATA_WIDTH (32),
        .NUM_LANES  (4),
        .BUF_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .lane_en_in    (lane_en_in),
        .lane_data_in  (lane_data_in),
        .row_valid_out (row_valid_out),
        .row_ready_in  (row_ready_in),
        .row_data_out  (row_data_out),
        .overflow_err  (overflow_err),
`ifdef ROW_COLLECTOR_CNT_EN
        .row_count_out     (row_count_out),
        .lane_skew_max_out (lane_skew_max_out),
`endif
        .err_clear_in  (err_clear_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row whose lane k holds base+k
    function automatic logic [127:0] mkrow(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [127:0] row;
        logic [127:0] expq[$];
        int           first_valid;

        rstn         = 1'b0;
        lane_en_in   = '0;
        lane_data_in = '0;
        row_ready_in = 1'b0;
        err_clear_in = 1'b0;
        tick();
        tick();
        chk("rst_valid", 128'(row_valid_out), 128'(0));
        chk("rst_data", row_data_out, 128'(0));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
`ifdef ROW_COLLECTOR_CNT_EN
        chk("rst_cnt", 128'(row_count_out), 128'(0));
        chk("rst_skew", 128'(lane_skew_max_out), 128'(0));
`endif
        rstn = 1'b1;
        tick();

        // 1: partial row on lanes 0..2, then async reset mid-stream
        lane_en_in   = 4'b0111;
        lane_data_in = mkrow(32'h0000_0900);
        tick();
        lane_en_in = '0;
        chk("t1_partial_valid", 128'(row_valid_out), 128'(0));
        rstn = 1'b0;
        #1;
        chk("t1_rst_valid", 128'(row_valid_out), 128'(0));
        chk("t1_rst_data", row_data_out, 128'(0));
        chk("t1_rst_ovf", 128'(overflow_err), 128'(0));
        tick();
        rstn = 1'b1;
        tick();
        lane_en_in   = 4'b1111;
        lane_data_in = mkrow(32'h0000_0A10);
        tick();
        lane_en_in = '0;
        chk("t1_row0_valid", 128'(row_valid_out), 128'(1));
        chk("t1_row0_data", row_data_out, mkrow(32'h0000_0A10));
        row_ready_in = 1'b1;
        tick();
        row_ready_in = 1'b0;
        chk("t1_after_pop", 128'(row_valid_out), 128'(0));

        // 2: aligned write, one-cycle latency
        row          = 128'h00000044_00000033_00000022_00000011;
        lane_en_in   = 4'b1111;
        lane_data_in = row;
        row_ready_in = 1'b1;
        chk("t2_pre_valid", 128'(row_valid_out), 128'(0));
        tick();
        lane_en_in = '0;
        chk("t2_valid", 128'(row_valid_out), 128'(1));
        chk("t2_data", row_data_out, row);
        tick();
        chk("t2_drained", 128'(row_valid_out), 128'(0));

        // 3: lane k strobes row r at cycle k+r, ready held high
        first_valid = -1;
        for (int c = 0; c < 10; c++) begin
            lane_en_in   = '0;
            lane_data_in = '0;
            for (int k = 0; k < 4; k++) begin
                if ((c - k >= 0) && (c - k <= 5)) begin
                    lane_en_in[k]              = 1'b1;
                    lane_data_in[k*32 +: 32]   = 32'h300 + 32'((c - k) * 16 + k);
                end
            end
            tick();
            if (row_valid_out && (first_valid < 0)) first_valid = c + 1;
            chk($sformatf("t3_valid_c%0d", c), 128'(row_valid_out), 128'((c >= 3) && (c <= 8)));
            if ((c >= 3) && (c <= 8)) begin
                chk($sformatf("t3_data_r%0d", c - 3), row_data_out, mkrow(32'h300 + 32'((c - 3) * 16)));
            end
        end
        lane_en_in = '0;
        chk("t3_first_valid", 128'(first_valid), 128'(4));
        chk("t3_ovf", 128'(overflow_err), 128'(0));
        row_ready_in = 1'b0;

        // 4: backpressure, lane0 overruns by one element
        for (int i = 0; i < 5; i++) begin
            lane_en_in   = 4'b0001;
            lane_data_in = 128'(32'h40 + 32'(i));
            tick();
            if (i == 3) chk("t4_ovf_at4", 128'(overflow_err), 128'(0));
        end
        lane_en_in = '0;
        chk("t4_ovf_at5", 128'(overflow_err), 128'(1));
        chk("t4_valid_partial", 128'(row_valid_out), 128'(0));
`ifdef ROW_COLLECTOR_CNT_EN
        chk("t4_skew", 128'(lane_skew_max_out), 128'(4));
`endif
        for (int r = 0; r < 4; r++) begin
            lane_en_in   = 4'b1110;
            lane_data_in = mkrow(32'h400 + 32'(r * 16));
            tick();
        end
        lane_en_in   = '0;
        row_ready_in = 1'b1;
        for (int r = 0; r < 4; r++) begin
            row = mkrow(32'h400 + 32'(r * 16));
            row[31:0] = 32'h40 + 32'(r);
            chk($sformatf("t4_valid_r%0d", r), 128'(row_valid_out), 128'(1));
            chk($sformatf("t4_data_r%0d", r), row_data_out, row);
            tick();
        end
        row_ready_in = 1'b0;
        chk("t4_drained", 128'(row_valid_out), 128'(0));
        chk("t4_ovf_sticky", 128'(overflow_err), 128'(1));
        err_clear_in = 1'b1;
        tick();
        err_clear_in = 1'b0;
        chk("t4_ovf_clear", 128'(overflow_err), 128'(0));

        // 5: fill buffer, drop-vs-clear priority, then pop+write every cycle
        for (int r = 0; r < 4; r++) begin
            lane_en_in   = 4'b1111;
            lane_data_in = mkrow(32'h600 + 32'(r * 16));
            expq.push_back(mkrow(32'h600 + 32'(r * 16)));
            tick();
        end
        lane_en_in   = 4'b0001;
        lane_data_in = mkrow(32'h0BAD_0000);
        err_clear_in = 1'b1;
        tick();
        lane_en_in   = '0;
        err_clear_in = 1'b0;
        chk("t5_set_wins", 128'(overflow_err), 128'(1));
        chk("t5_full_valid", 128'(row_valid_out), 128'(1));
        chk("t5_full_data", row_data_out, mkrow(32'h600));
        err_clear_in = 1'b1;
        tick();
        err_clear_in = 1'b0;
        chk("t5_ovf_clear", 128'(overflow_err), 128'(0));
        row_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lane_en_in   = 4'b1111;
            lane_data_in = mkrow(32'h700 + 32'(i * 16));
            chk($sformatf("t5_stream_valid%0d", i), 128'(row_valid_out), 128'(1));
            chk($sformatf("t5_stream_data%0d", i), row_data_out, expq.pop_front());
            expq.push_back(mkrow(32'h700 + 32'(i * 16)));
            tick();
            chk($sformatf("t5_stream_ovf%0d", i), 128'(overflow_err), 128'(0));
        end
        lane_en_in = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_drain_valid%0d", i), 128'(row_valid_out), 128'(1));
            chk($sformatf("t5_drain_data%0d", i), row_data_out, expq.pop_front());
            tick();
        end
        row_ready_in = 1'b0;
        chk("t5_empty", 128'(row_valid_out), 128'(0));

`ifdef ROW_COLLECTOR_CNT_EN
        // 6: counter wrap from a fresh reset, one pop per cycle after the first write
        rstn = 1'b0;
        tick();
        rstn         = 1'b1;
        lane_en_in   = 4'b1111;
        lane_data_in = mkrow(32'h800);
        row_ready_in = 1'b1;
        for (int t = 0; t < 65535; t++) begin
            tick();
        end
        chk("t6_cnt_fffe", 128'(row_count_out), 128'(16'hFFFE));
        chk("t6_skew", 128'(lane_skew_max_out), 128'(1));
        tick();
        tick();
        chk("t6_cnt_wrap", 128'(row_count_out), 128'(0));
        lane_en_in   = '0;
        row_ready_in = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
